// File: rtl/multicycle_pkg.sv
// Shared state encodings, instruction-class constants and control word
// for the multicycle controller.
package multicycle_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  localparam logic [1:0] OP_LDR = 2'b00;
  localparam logic [1:0] OP_STR = 2'b01;
  localparam logic [1:0] OP_B   = 2'b10;
  localparam logic [1:0] OP_DP  = 2'b11;

  typedef struct packed {
    logic       irwrite;
    logic       nextpc;
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       aluop;
    logic       regw;
    logic       memw;
    logic       branch;
  } ctrl_t;

endpackage

// File: rtl/mc_output_decoder.sv
// Combinational state-to-control-word decode plus Op-driven immediate and
// register-address selects.
module mc_output_decoder
  import multicycle_pkg::*;
(
  input  state_t     state,
  input  logic       memready,
  input  logic [1:0] op,
  output ctrl_t      ctrl,
  output logic [1:0] immsrc,
  output logic [1:0] regsrc
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.alusrca   = 1'b1;
        ctrl.alusrcb   = 2'b10;
        ctrl.resultsrc = 2'b10;
        ctrl.irwrite   = memready;
        ctrl.nextpc    = memready;
      end
      DECODE: begin
        ctrl.alusrca   = 1'b1;
        ctrl.alusrcb   = 2'b10;
        ctrl.resultsrc = 2'b10;
      end
      MEMADR: begin
        ctrl.alusrcb = 2'b01;
      end
      MEMREAD: begin
        ctrl.adrsrc = 1'b1;
      end
      MEMWB: begin
        ctrl.resultsrc = 2'b01;
        ctrl.regw      = 1'b1;
      end
      MEMWRITE: begin
        ctrl.adrsrc = 1'b1;
        ctrl.memw   = 1'b1;
      end
      EXECR: begin
        ctrl.aluop = 1'b1;
      end
      EXECI: begin
        ctrl.alusrcb = 2'b01;
        ctrl.aluop   = 1'b1;
      end
      ALUWB: begin
        ctrl.regw = 1'b1;
      end
      BRANCH: begin
        ctrl.alusrcb   = 2'b01;
        ctrl.resultsrc = 2'b10;
        ctrl.branch    = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  always_comb begin
    immsrc = 2'b00;
    regsrc = 2'b00;
    case (op)
      OP_LDR: begin immsrc = 2'b01; regsrc = 2'b00; end
      OP_STR: begin immsrc = 2'b01; regsrc = 2'b10; end
      OP_B:   begin immsrc = 2'b10; regsrc = 2'b01; end
      default: begin immsrc = 2'b00; regsrc = 2'b00; end
    endcase
  end

endmodule

// File: rtl/multicycle_fsm.sv
// Multicycle processor main controller: state register and next-state logic,
// with the control word produced by mc_output_decoder.
module multicycle_fsm
  import multicycle_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [3:0] State
);

  state_t state_q;
  state_t state_d;
  state_t dec_state;
  ctrl_t  ctrl;
  logic   unused_funct;

  assign unused_funct = ^Funct[4:0];

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = MemReady ? DECODE : FETCH;
      DECODE: begin
        case (Op)
          OP_LDR, OP_STR: state_d = MEMADR;
          OP_B:           state_d = BRANCH;
          default:        state_d = Funct[5] ? EXECI : EXECR;
        endcase
      end
      MEMADR: begin
        case (Op)
          OP_LDR:  state_d = MEMREAD;
          OP_STR:  state_d = MEMWRITE;
          default: state_d = FETCH;
        endcase
      end
      MEMREAD:  state_d = MemReady ? MEMWB : MEMREAD;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = MemReady ? FETCH : MEMWRITE;
      EXECR:    state_d = ALUWB;
      EXECI:    state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      default:  state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // While reset is held the decoder sees FETCH with MemReady masked, so the
  // mux selects read as FETCH and every enable stays low.
  assign dec_state = reset ? FETCH : state_q;

  mc_output_decoder u_dec (
    .state    (dec_state),
    .memready (MemReady & ~reset),
    .op       (Op),
    .ctrl     (ctrl),
    .immsrc   (ImmSrc),
    .regsrc   (RegSrc)
  );

  assign IRWrite   = ctrl.irwrite;
  assign NextPC    = ctrl.nextpc;
  assign AdrSrc    = ctrl.adrsrc;
  assign ALUSrcA   = ctrl.alusrca;
  assign ALUSrcB   = ctrl.alusrcb;
  assign ResultSrc = ctrl.resultsrc;
  assign ALUOp     = ctrl.aluop;
  assign RegW      = ctrl.regw;
  assign MemW      = ctrl.memw;
  assign Branch    = ctrl.branch;
  assign State     = state_q;

endmodule
